// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC, PC+4 incrementer, byte-addressed
// big-endian instruction memory with a load port, and the instruction register.
// Supports stall, branch redirect with squash, run/halt control and a sticky
// address-fault flag. Decoded register/opcode fields are slices of INSTRUCTION.

module fetch_unit #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        STALL,
  input  logic        BRANCH_EN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        LOAD_EN,
  input  logic [31:0] LOAD_ADDR,
  input  logic [31:0] LOAD_DATA,
  output logic [31:0] PC_OUT,
  output logic [31:0] INSTRUCTION,
  output logic [4:0]  ReadReg1,
  output logic [4:0]  ReadReg2,
  output logic [4:0]  WriteReg,
  output logic [5:0]  FuncCode,
  output logic [5:0]  OpCode,
  output logic        VALID,
  output logic        FAULT,
  output logic        HALTED
);

  localparam int unsigned AW       = $clog2(DEPTH_BYTES);
  // Highest byte address at which a whole word still fits in memory.
  localparam logic [31:0] LastWord = 32'(DEPTH_BYTES - 4);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [AW-1:0] rd_base;
  logic [31:0]   mem_word;
  logic          fetch_fault;
  logic          halt_seen;
  logic          unused_load_addr;

  // Memory index bits only; upper address bits wrap and [1:0] are forced to zero.
  assign unused_load_addr = ^{LOAD_ADDR[31:AW], LOAD_ADDR[1:0]};

  // Combinational big-endian read at the fetch pointer (index wraps within memory).
  always_comb begin
    rd_base  = fpc_q[AW-1:0];
    mem_word = {mem_q[rd_base],
                mem_q[rd_base + AW'(1)],
                mem_q[rd_base + AW'(2)],
                mem_q[rd_base + AW'(3)]};
  end

  assign fetch_fault = (fpc_q[1:0] != 2'b00) || (fpc_q > LastWord);
  // A pending fault or a live HALT_WORD in the register ends fetching.
  assign halt_seen   = fault_q || (valid_q && (instr_q == HALT_WORD));

  // Load port: word write, big-endian, no reset; same-cycle fetch sees old data.
  always_ff @(posedge CLK) begin
    if (LOAD_EN) begin
      mem_q[{LOAD_ADDR[AW-1:2], 2'd0}] <= LOAD_DATA[31:24];
      mem_q[{LOAD_ADDR[AW-1:2], 2'd1}] <= LOAD_DATA[23:16];
      mem_q[{LOAD_ADDR[AW-1:2], 2'd2}] <= LOAD_DATA[15:8];
      mem_q[{LOAD_ADDR[AW-1:2], 2'd3}] <= LOAD_DATA[7:0];
    end
  end

  // Next-state logic: FSM plus fetch datapath, priority halt > branch > stall > fetch.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (START) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (halt_seen) begin
          state_d = StHalt;
          valid_d = 1'b0;
        end else if (BRANCH_EN) begin
          // Squash the in-flight fetch; the target is fetched on the next edge.
          fpc_d   = BRANCH_TARGET;
          valid_d = 1'b0;
        end else if (STALL) begin
          // Hold everything.
        end else if (fetch_fault) begin
          fault_d = 1'b1;
          valid_d = 1'b0;
          instr_d = 32'h0;
        end else begin
          instr_d = mem_word;
          pc_d    = fpc_q;
          valid_d = 1'b1;
          fpc_d   = fpc_q + 32'd4;
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      fpc_q   <= RESET_PC;
      instr_q <= 32'h0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign PC_OUT      = pc_q;
  assign INSTRUCTION = instr_q;
  assign VALID       = valid_q;
  assign FAULT       = fault_q;
  assign HALTED      = (state_q == StHalt);
  assign OpCode      = instr_q[31:26];
  assign ReadReg1    = instr_q[25:21];
  assign ReadReg2    = instr_q[20:16];
  assign WriteReg    = instr_q[15:11];
  assign FuncCode    = instr_q[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (64-byte memory); expected fetches are
// queued from a word-level memory model and compared as the DUT presents them.

module tb_fetch_unit;

  localparam int unsigned NWORDS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_data = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [5:0]  func_code, op_code;
  logic        valid, fault, halted;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] model_mem [NWORDS];
  int          checks = 0;
  int          failures = 0;

  fetch_unit #(
    .DEPTH_BYTES(64),
    .RESET_PC   (32'h0),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .START        (start),
    .STALL        (stall),
    .BRANCH_EN    (branch_en),
    .BRANCH_TARGET(branch_target),
    .LOAD_EN      (load_en),
    .LOAD_ADDR    (load_addr),
    .LOAD_DATA    (load_data),
    .PC_OUT       (pc_out),
    .INSTRUCTION  (instruction),
    .ReadReg1     (read_reg1),
    .ReadReg2     (read_reg2),
    .WriteReg     (write_reg),
    .FuncCode     (func_code),
    .OpCode       (op_code),
    .VALID        (valid),
    .FAULT        (fault),
    .HALTED       (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start     = 1'b0;
    stall     = 1'b0;
    branch_en = 1'b0;
    load_en   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en = 1'b0;
    model_mem[addr[5:2]] = data;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++;
    if (pc_out !== 32'h0 || instruction !== 32'h0 || valid !== 1'b0 ||
        fault !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b fault=%b halted=%b, want 0/0/0/0/0",
               pc_out, instruction, valid, fault, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NWORDS; i++) begin
      if (i == 0) load_word(32'h0, 32'h0801_1000);
      else if (i == 1) load_word(32'h4, 32'h0064_2800);
      else load_word(32'(i * 4), {8'h20, 8'(i), 8'(i * 3), 8'(i * 5)});
    end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL start_bubble: valid=%b want 0", valid);
    end
    exp_q.push_back('{pc: 32'h0, instr: model_mem[0]});
    exp_q.push_back('{pc: 32'h4, instr: model_mem[1]});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin
        failures++;
        $display("FAIL basic_fetch%0d: valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                 i, valid, pc_out, instruction, e.pc, e.instr);
      end
      checks++;
      if (read_reg1 !== 5'(i * 3) || read_reg2 !== 5'(i * 3 + 1) ||
          write_reg !== 5'(i * 3 + 2)) begin
        failures++;
        $display("FAIL fields%0d: rr1=%0d rr2=%0d wr=%0d, want %0d/%0d/%0d",
                 i, read_reg1, read_reg2, write_reg, i * 3, i * 3 + 1, i * 3 + 2);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back('{pc: 32'(i * 4), instr: model_mem[i]});
    tick();
    e = exp_q.pop_front();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                 i, valid, pc_out, instruction, e.pc, e.instr);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin
        failures++;
        $display("FAIL stall_resume%0d: valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                 i, valid, pc_out, instruction, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    // At PC 4 now; branch and stall together, branch must win.
    exp_q.push_back('{pc: 32'h10, instr: model_mem[4]});
    exp_q.push_back('{pc: 32'h14, instr: model_mem[5]});
    branch_en     = 1'b1;
    branch_target = 32'h10;
    stall         = 1'b1;
    tick();
    branch_en = 1'b0;
    stall     = 1'b0;
    checks++;
    if (valid !== 1'b0 || pc_out !== 32'h4 || instruction !== model_mem[1]) begin
      failures++;
      $display("FAIL branch_bubble: valid=%b pc=%h instr=%h, want 0 pc=00000004 instr=%h",
               valid, pc_out, instruction, model_mem[1]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin
        failures++;
        $display("FAIL branch_target%0d: valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                 i, valid, pc_out, instruction, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_fault_misaligned();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    branch_en     = 1'b1;
    branch_target = 32'h6;
    tick();
    branch_en = 1'b0;
    tick();
    checks++;
    if (fault !== 1'b1 || instruction !== 32'h0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_fault: fault=%b instr=%h valid=%b, want 1/00000000/0",
               fault, instruction, valid);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || fault !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_halt: halted=%b fault=%b valid=%b, want 1/1/0",
               halted, fault, valid);
    end
  endtask

  task automatic test_fault_range();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NWORDS; i++) exp_q.push_back('{pc: 32'(i * 4), instr: model_mem[i]});
    for (int i = 0; i < NWORDS; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin
        failures++;
        $display("FAIL seq_run%0d: valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                 i, valid, pc_out, instruction, e.pc, e.instr);
      end
    end
    tick();
    checks++;
    if (fault !== 1'b1 || instruction !== 32'h0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL range_fault: fault=%b instr=%h valid=%b, want 1/00000000/0",
               fault, instruction, valid);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL range_halt: halted=%b valid=%b, want 1/0", halted, valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_out !== 32'h0 || instruction !== 32'h0 || valid !== 1'b0 ||
        fault !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: pc=%h instr=%h valid=%b fault=%b halted=%b, want all 0",
               pc_out, instruction, valid, fault, halted);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (valid !== 1'b0 || pc_out !== 32'h0) begin
      failures++;
      $display("FAIL idle_after_reset: valid=%b pc=%h, want 0 pc=00000000", valid, pc_out);
    end
  endtask

  task automatic test_load_collision();
    logic [31:0] old_w0;
    do_reset();
    // Out-of-range load wraps onto word 1.
    load_word(32'h44, 32'h1234_5678);
    start = 1'b1;
    tick();
    start = 1'b0;
    old_w0 = model_mem[0];
    exp_q.push_back('{pc: 32'h0, instr: old_w0});
    exp_q.push_back('{pc: 32'h4, instr: 32'h1234_5678});
    exp_q.push_back('{pc: 32'h0, instr: 32'hCAFE_0001});
    // Overwrite the word being fetched this very cycle (low bits ignored).
    load_en   = 1'b1;
    load_addr = 32'h3;
    load_data = 32'hCAFE_0001;
    tick();
    load_en = 1'b0;
    model_mem[0] = 32'hCAFE_0001;
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin
      failures++;
      $display("FAIL collide_old: pc=%h instr=%h, want pc=%h instr=%h",
               pc_out, instruction, e.pc, e.instr);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin
      failures++;
      $display("FAIL load_wrap: pc=%h instr=%h, want pc=%h instr=%h",
               pc_out, instruction, e.pc, e.instr);
    end
    branch_en     = 1'b1;
    branch_target = 32'h0;
    tick();
    branch_en = 1'b0;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin
      failures++;
      $display("FAIL collide_new: pc=%h instr=%h, want pc=%h instr=%h",
               pc_out, instruction, e.pc, e.instr);
    end
  endtask

  task automatic test_halt_word();
    do_reset();
    load_word(32'h8, 32'hFFFF_FFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back('{pc: 32'(i * 4), instr: model_mem[i]});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr || halted !== 1'b0) begin
        failures++;
        $display("FAIL halt_run%0d: valid=%b pc=%h instr=%h halted=%b, want 1 pc=%h instr=%h 0",
                 i, valid, pc_out, instruction, halted, e.pc, e.instr);
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || valid !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL halt_enter: halted=%b valid=%b fault=%b, want 1/0/0", halted, valid, fault);
    end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if (halted !== 1'b1 || valid !== 1'b0 || pc_out !== 32'h8) begin
      failures++;
      $display("FAIL halt_terminal: halted=%b valid=%b pc=%h, want 1/0/00000008",
               halted, valid, pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_branch();
    test_fault_misaligned();
    test_fault_range();
    test_async_reset();
    test_load_collision();
    test_halt_word();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the MIPS ALU datapath. It combines the program counter, PC+4 incrementer, byte-addressed big-endian instruction memory and instruction register into one clocked block. It adds the following behaviour:
- stall
- branch redirect with squash
- run/halt control
- loadable program memory
- address-fault detection

It feeds the register file and ALU decode stage.

## Interface
Parameters:
- DEPTH_BYTES, 1024, instruction-memory size in bytes; must be a multiple of 4 and a power of two.
- RESET_PC, 32'h0, PC value loaded on reset; must be word-aligned.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- CLK  input  1  single clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  level; moves IDLE to RUN.
- STALL  input  1  hold PC and instruction register this cycle.
- BRANCH_EN  input  1  redirect PC to BRANCH_TARGET this cycle.
- BRANCH_TARGET  input  32  byte address of the redirect.
- LOAD_EN  input  1  write one word into instruction memory.
- LOAD_ADDR  input  32  byte address of the load; bits [1:0] ignored.
- LOAD_DATA  input  32  word stored big-endian: [31:24] goes to the lowest byte.
- PC_OUT  output  32  address of the instruction held in INSTRUCTION.
- INSTRUCTION  output  32  instruction register.
- ReadReg1  output  5  INSTRUCTION[25:21].
- ReadReg2  output  5  INSTRUCTION[20:16].
- WriteReg  output  5  INSTRUCTION[15:11].
- FuncCode  output  6  INSTRUCTION[5:0].
- OpCode  output  6  INSTRUCTION[31:26].
- VALID  output  1  INSTRUCTION holds a live instruction.
- FAULT  output  1  sticky; set by a misaligned or out-of-range fetch address.
- HALTED  output  1  FSM in HALT.

## Operation
- Internal state: the fetch pointer FPC (32 bits), the instruction register, PC_OUT, VALID, FAULT and the FSM.
- Memory is combinational-read at FPC. It returns bytes FPC..FPC+3 concatenated MSB-first.
- FSM states and transitions:
  - IDLE: START=1 → RUN.
  - RUN: every non-stalled cycle latches the memory word and advances FPC by 4.
  - RUN → HALT when a latched word equals HALT_WORD, or when a fault is detected.
  - HALT: terminal until reset.
- RUN, per cycle, with priority BRANCH_EN > STALL > normal:
  - BRANCH_EN=1: FPC ← BRANCH_TARGET; VALID ← 0 (squashes the in-flight fetch); instruction register and PC_OUT hold.
  - STALL=1, BRANCH_EN=0: all registers hold.
  - Normal:
    - INSTRUCTION ← mem[FPC].
    - PC_OUT ← FPC.
    - VALID ← 1.
    - FPC ← FPC+4, wrapping modulo 2^32.
- Fault conditions, checked on any non-stalled RUN cycle before latching:
  - FPC[1:0] ≠ 0, or FPC > DEPTH_BYTES−4.
  - Response: FAULT ← 1; VALID ← 0; INSTRUCTION ← 0 (NOP); HALT next cycle.
- A latched HALT_WORD is presented with VALID=1 for exactly one cycle. The FSM then enters HALT.
- HALT and IDLE: VALID=0; FPC and the instruction register hold.
- Load port:
  - Active in every state.
  - Writes four bytes at LOAD_ADDR & ~3, masked to the memory range. Out-of-range writes wrap.
  - A fetch of the same word in the same cycle returns the old contents.
- Memory contents are not affected by reset.
- Decoded field outputs are pure slices of INSTRUCTION.

## Timing
- RESET low, asynchronous, sets:
  - FSM = IDLE; FPC = RESET_PC; PC_OUT = RESET_PC.
  - INSTRUCTION = 0; VALID = 0; FAULT = 0; HALTED = 0.
- Reset asserted mid-RUN clears all state immediately, independent of CLK. Fetch restarts only after START.
- START sampled in IDLE → RUN on that edge. The first instruction latches on the next edge: VALID rises 2 edges after START is sampled.
- Latency of fetch address to INSTRUCTION is 1 cycle. Throughput is 1 instruction/cycle with no stall.
- After a branch, the target instruction appears with VALID=1 on the second edge after BRANCH_EN: one bubble.
- BRANCH_EN and STALL together: branch wins; the redirect is never lost.
- HALTED rises on the edge after the HALT_WORD or fault cycle.

## Test plan
- Reset, load words 0x08011000 @0 and 0x0064_2800 @4, START, run 2 cycles → PC_OUT 0 then 4; ReadReg1/ReadReg2/WriteReg = 0/1/2, then 3/4/5; VALID=1.
- STALL high for 3 cycles after the first fetch → INSTRUCTION, PC_OUT and VALID frozen; after release the next PC_OUT=4, with no skip or duplicate.
- BRANCH_EN with target 0x10 while at PC 4, STALL also high → VALID=0 for one cycle, then PC_OUT=0x10 with the word at 0x10.
- Branch to 0x6 → FAULT=1, INSTRUCTION=0, VALID=0, HALTED=1 next cycle. With DEPTH_BYTES=64, sequential run past 0x3C → same result.
- HALT_WORD stored at 0x8 → VALID=1 with 0xFFFFFFFF at PC 8 for one cycle, then HALTED=1 and VALID=0. START has no effect until reset.
- Assert RESET low mid-RUN between clock edges → outputs immediately at reset values. LOAD_EN to the word being fetched in the same cycle → old word latched, new word read on the next visit.
